// File: rtl/bram_fifo_pkg.sv
// Shared constants and helpers for the BRAM-backed stream FIFO.
package bram_fifo_pkg;

  localparam int DEF_WIDTH  = 72;
  localparam int SKID_DEPTH = 2;  // head + skid words held outside the RAM

  // Width needed to hold a count of 0..depth inclusive.
  function automatic int clog2p1(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// No reset on the array or read register so the tools map it onto block RAM.
module sdp_ram #(
  parameter int WIDTH     = 72,
  parameter int LOG_DEPTH = 9
) (
  input  logic                 clk,
  input  logic [LOG_DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 we,
  input  logic [LOG_DEPTH-1:0] raddr,
  input  logic                 re,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [2**LOG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bram_stream_fifo.sv
// First-word-fall-through stream FIFO: BRAM storage plus a head/skid output stage.
// Optional high-water mark (hwm, hwm_clr) is enabled by defining BRAM_FIFO_HWM_EN.
module bram_stream_fifo
  import bram_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = 512,
  parameter int LOG_DEPTH = $clog2(DEPTH),
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [WIDTH-1:0]     ss_data,
  input  logic                 ss_valid,
  output logic                 ss_ready,
  output logic [WIDTH-1:0]     ms_data,
  output logic                 ms_valid,
  input  logic                 ms_ready,
  output logic [LOG_DEPTH:0]   level,
  output logic                 almost_full,
  output logic                 almost_empty
`ifdef BRAM_FIFO_HWM_EN
  ,
  input  logic                 hwm_clr,
  output logic [LOG_DEPTH:0]   hwm
`endif
);

  localparam int LW = LOG_DEPTH + 1;

  logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]        ram_cnt, level_next;
  logic                 skid_valid, rd_inflight;
  logic [WIDTH-1:0]     skid_data, rdata;
  logic                 push, pop, rd_issue, head_take;
  logic [2:0]           occ;

  sdp_ram #(.WIDTH(WIDTH), .LOG_DEPTH(LOG_DEPTH)) u_ram (
    .clk   (clk),
    .waddr (wr_ptr),
    .wdata (ss_data),
    .we    (push),
    .raddr (rd_ptr),
    .re    (rd_issue),
    .rdata (rdata)
  );

  always_comb begin
    push       = ss_valid && ss_ready;
    pop        = ms_valid && ms_ready;
    // Words already committed to the output stage after this edge's pop.
    occ        = 3'(ms_valid) + 3'(skid_valid) + 3'(rd_inflight) - 3'(pop);
    rd_issue   = (ram_cnt != '0) && (occ < 3'(SKID_DEPTH));
    head_take  = !ms_valid || pop;
    level_next = level + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
      level       <= '0;
      ss_ready    <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + LOG_DEPTH'(push);
      rd_ptr      <= rd_ptr + LOG_DEPTH'(rd_issue);
      ram_cnt     <= ram_cnt + LW'(push) - LW'(rd_issue);
      rd_inflight <= rd_issue;
      level       <= level_next;
      ss_ready    <= level_next < LW'(DEPTH);
    end
  end

  // Returning read data goes to the head when it frees up, else parks in the skid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_data    <= '0;
      ms_valid   <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (head_take) begin
      if (skid_valid) begin
        ms_data    <= skid_data;
        ms_valid   <= 1'b1;
        skid_valid <= rd_inflight;
        if (rd_inflight) skid_data <= rdata;
      end else if (rd_inflight) begin
        ms_data  <= rdata;
        ms_valid <= 1'b1;
      end else begin
        ms_valid <= 1'b0;
      end
    end else if (rd_inflight) begin
      skid_data  <= rdata;
      skid_valid <= 1'b1;
    end
  end

  assign almost_full  = level >= LW'(AF_THRESH);
  assign almost_empty = level <= LW'(AE_THRESH);

`ifdef BRAM_FIFO_HWM_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          hwm <= '0;
    else if (hwm_clr)     hwm <= level;
    else if (level > hwm) hwm <= level;
  end
`endif

endmodule

// File: tb/tb_bram_stream_fifo.sv
// Directed bench for bram_stream_fifo: driver records accepted words in a queue,
// a negedge monitor pops and compares every handshake on the output side.
module tb_bram_stream_fifo;

  localparam int WIDTH     = 16;
  localparam int DEPTH     = 64;
  localparam int LOG_DEPTH = 6;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic [WIDTH-1:0]     ss_data = '0;
  logic                 ss_valid = 1'b0;
  logic                 ss_ready;
  logic [WIDTH-1:0]     ms_data;
  logic                 ms_valid;
  logic                 ms_ready = 1'b0;
  logic [LOG_DEPTH:0]   level;
  logic                 almost_full, almost_empty;

  int checks = 0;
  int passes = 0;
  int pops   = 0;
  logic [WIDTH-1:0] exp_q [$];
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data  = '0;

  bram_stream_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH),
    .AF_THRESH(DEPTH - 4), .AE_THRESH(4)
  ) dut (
    .clk(clk), .resetn(resetn),
    .ss_data(ss_data), .ss_valid(ss_valid), .ss_ready(ss_ready),
    .ms_data(ms_data), .ms_valid(ms_valid), .ms_ready(ms_ready),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    ss_valid = 1'b0;
    ms_ready = 1'b1;
    for (int n = 0; n < 4 * DEPTH + 16 && (level != 0 || ms_valid); n++) step();
    ms_ready = 1'b0;
    chk(name, level, 0);
    chk({name, "_valid"}, ms_valid, 0);
  endtask

  // Expected stream: every word the FIFO accepts.
  always @(negedge clk) begin
    if (resetn && ss_valid && ss_ready) exp_q.push_back(ss_data);
  end

  // Output monitor: ordering, stall stability, level range.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", ms_valid, 1);
        chk("stall_data", ms_data, prev_data);
      end
      chk("level_range", (level <= DEPTH), 1);
      if (ms_valid && ms_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL pop_unexpected: got %0h expected no word", ms_data);
        end else begin
          chk("pop_data", ms_data, exp_q.pop_front());
        end
        pops++;
      end
      prev_stall = ms_valid && !ms_ready;
      prev_data  = ms_data;
    end
  end

  initial begin
    logic [WIDTH-1:0] val;
    logic             acc;
    int               words;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ss_ready", ss_ready, 0);
    chk("rst_ms_valid", ms_valid, 0);
    chk("rst_ms_data", ms_data, 0);
    chk("rst_level", level, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ae", almost_empty, 1);
    resetn = 1'b1;
    step();
    chk("rel_ss_ready", ss_ready, 1);

    // 1: single word, two-cycle write-to-head latency
    ss_valid = 1'b1; ss_data = 16'h00A5;
    step();
    ss_valid = 1'b0;
    chk("t1_level_e0", level, 1);
    chk("t1_valid_e0", ms_valid, 0);
    step();
    chk("t1_valid_e1", ms_valid, 0);
    step();
    chk("t1_valid_e2", ms_valid, 1);
    chk("t1_data", ms_data, 16'h00A5);
    chk("t1_level", level, 1);
    chk("t1_ae", almost_empty, 1);
    ms_ready = 1'b1;
    step();
    ms_ready = 1'b0;
    chk("t1_level_after_pop", level, 0);

    // 2: fill to DEPTH with consumer stalled
    for (int i = 0; i < DEPTH; i++) begin
      ss_valid = 1'b1; ss_data = WIDTH'(i);
      step();
      if (i == DEPTH - 6) chk("t2_af_below", almost_full, 0);
      if (i == DEPTH - 5) chk("t2_af_at", almost_full, 1);
      if (i == 4)         chk("t2_ae_off", almost_empty, 0);
    end
    ss_valid = 1'b1; ss_data = 16'hDEAD;  // must be ignored while full
    step();
    chk("t2_level_full", level, DEPTH);
    chk("t2_ss_ready_full", ss_ready, 0);
    chk("t2_af_full", almost_full, 1);

    // 4: single pop at full reopens ss_ready next cycle
    ms_ready = 1'b1;
    step();
    ms_ready = 1'b0; ss_valid = 1'b0;
    chk("t4_level", level, DEPTH - 1);
    chk("t4_ss_ready", ss_ready, 1);
    ss_valid = 1'b1; ss_data = 16'h0100;
    step();
    ss_valid = 1'b0;
    chk("t4_refill", level, DEPTH);
    chk("t4_ss_ready_closed", ss_ready, 0);
    drain("t2_drain");
    chk("t2_ae_empty", almost_empty, 1);

    // 3: continuous streaming across three pointer wraps
    val = 16'h1000;
    ss_valid = 1'b1; ms_ready = 1'b1;
    for (int c = 0; c < 3 * DEPTH; c++) begin
      ss_data = val;
      step();
      val++;
      if (c >= 2) begin
        chk("t3_level", level, 3);
        chk("t3_valid", ms_valid, 1);
      end
    end
    drain("t3_drain");

    // 5: random producer/consumer
    val = 16'h4000; words = 0;
    for (int c = 0; c < 60000 && words < 10000; c++) begin
      ss_valid = ($urandom_range(3) != 0);
      ms_ready = $urandom_range(1) != 0;
      ss_data  = val;
      acc      = ss_valid && ss_ready;
      step();
      if (acc) begin
        val++;
        words++;
      end
    end
    chk("t5_words", words, 10000);
    drain("t5_drain");

    // 6: async reset mid-stream at level 37
    for (int i = 0; i < 37; i++) begin
      ss_valid = 1'b1; ss_data = WIDTH'(16'h7000 + i);
      step();
    end
    ss_valid = 1'b0;
    step();
    chk("t6_level", level, 37);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_ms_valid", ms_valid, 0);
    chk("t6_ss_ready", ss_ready, 0);
    chk("t6_level_rst", level, 0);
    chk("t6_ms_data", ms_data, 0);
    chk("t6_ae", almost_empty, 1);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    step();
    chk("t6_ss_ready_rel", ss_ready, 1);
    pops = 0;
    ss_valid = 1'b1; ss_data = 16'hBEEF;
    step();
    ss_valid = 1'b0;
    drain("t6_drain");
    chk("t6_pops", pops, 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bram_stream_fifo.md
Name: bram_stream_fifo

Overview:
Parametrised, BRAM-backed, first-word-fall-through stream FIFO with valid/ready handshakes on both sides. It is the general successor to the fixed 72x512 accelerator-wrapper FIFO. It adds:
- correct full/empty tracking;
- a bubble-free 2-entry output prefetch stage;
- level and almost-full/almost-empty flags.

It sits between the AXI-stream side of the wrapper and accelerator cores.

Parameters:
WIDTH, 72, data word width in bits (1..512)
DEPTH, 512, total capacity in words; power of two, >= 4
LOG_DEPTH, $clog2(DEPTH), address width; level width is LOG_DEPTH+1
AF_THRESH, DEPTH-4, almost_full asserts when level >= AF_THRESH
AE_THRESH, 4, almost_empty asserts when level <= AE_THRESH

Ports:
clk  in  1  single clock
resetn  in  1  asynchronous, active-low reset
ss_data  in  WIDTH  slave-stream write data
ss_valid  in  1  write request
ss_ready  out  1  FIFO can accept a word (registered)
ms_data  out  WIDTH  head word (registered)
ms_valid  out  1  head word valid (registered)
ms_ready  in  1  consumer accepts head
level  out  LOG_DEPTH+1  words held, 0..DEPTH
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH

Behaviour:
- Reset (async assert, sync release on clk): ss_ready=0, ms_valid=0, ms_data=0, level=0, almost_full=0, almost_empty=1; pointers, ram_cnt, skid and in-flight flag cleared. Reset mid-transfer discards all contents; no partial word survives.
- Push = ss_valid && ss_ready. Pop = ms_valid && ms_ready. Both are evaluated at the same posedge.
- Storage structure:
  - RAM: simple dual-port, 1-cycle synchronous read. wr_ptr and rd_ptr are LOG_DEPTH bits and wrap DEPTH-1 -> 0 naturally.
  - Output stage: head register (ms_data/ms_valid) plus one skid register.
  - ram_cnt counts words resident in RAM.
- RAM read issue: when ram_cnt > 0 and (head_valid + skid_valid + rd_inflight - pop) < 2. Returning data fills the head if the head is empty or popping; otherwise it fills the skid. The skid drains into the head on pop.
- level = ram_cnt + rd_inflight + skid_valid + head_valid. Push increments it, pop decrements it, and simultaneous push+pop leaves it unchanged. Width LOG_DEPTH+1, so level==DEPTH is representable.
- ss_ready is registered: next-state is (level_next < DEPTH) && resetn. At full, a simultaneous pop reopens ss_ready on the following cycle (one-cycle bubble is intended). ss_ready is 1 in the first cycle after reset release.
- Latency: word pushed at edge E0 into an empty FIFO -> RAM read issued in cycle E0..E1 -> ms_valid=1 after E2. Two cycles, write to head.
- Throughput: with ss_valid=ms_ready=1 continuously and the FIFO non-empty, one word per cycle in and out with no bubbles.
- ms_data is stable while ms_valid && !ms_ready. ms_valid never drops without a pop.
- Empty: ms_valid=0; a pop is impossible. Full: ss_ready=0; ss_data is ignored.
- almost_full and almost_empty are combinational compares on the registered level.
- Ordering is strict FIFO, including across pointer wrap.

Optional Feature:
Macro BRAM_FIFO_HWM_EN.
- Defined: adds ports hwm_clr (in, 1) and hwm (out, LOG_DEPTH+1).
  - hwm registers the maximum level seen since reset or since the last hwm_clr.
  - hwm_clr=1 at an edge loads hwm with the current level.
  - Reset value 0.
- Undefined: the ports and register are absent; the remaining behaviour is identical.

Decomposition:
- Package bram_fifo_pkg: the level-width function clog2p1(DEPTH), a default WIDTH constant of 72, and a localparam for skid stage depth of 2.
- Sub-module sdp_ram (WIDTH, LOG_DEPTH): one write port (waddr, wdata, we) and one read port (raddr, re, rdata registered on re). No reset on the array; infers BRAM.
- The FIFO top holds all control.

Test Plan:
1. Reset then single push of 0xA5 -> ms_valid=1 exactly 2 cycles after the push edge; ms_data=0xA5; level=1; almost_empty=1.
2. Fill with ms_ready=0: DEPTH pushes of the incrementing values 0..DEPTH-1 -> level=DEPTH, ss_ready=0, almost_full=1 from level DEPTH-4. Then drain -> values are read in order, and level returns to 0.
3. Streaming: ss_valid=ms_ready=1 for 3*DEPTH cycles -> one pop per cycle after the initial latency, data in order across 3 pointer wraps, level constant.
4. Full plus simultaneous push/pop: at level=DEPTH, pop once -> ss_ready=1 on the next cycle and level=DEPTH-1; no data loss or duplication.
5. Random ms_ready backpressure (50%) with random ss_valid, 10k words -> scoreboard match, ms_data stable while stalled, level always in 0..DEPTH.
6. Assert resetn low mid-stream with level=37 -> all outputs immediately reach their reset values (async); after release, the first new push is the first word popped.
